// File: rtl/stream_upsizer.sv
// -----------------------------------------------------------------------------
// stream_upsizer
//
// Purpose:
//   Packs 2**RATIO_R narrow DATA_W beats into one wide word with little-endian
//   lanes. Lane k of the wide word is the k-th beat of that word. A beat with
//   i_last closes the word early. Lanes that were never filled read as zero,
//   and their o_keep bit is clear. This block sits in the slave clock domain,
//   directly behind the read port of an async FIFO.
//
// Configuration macro:
//   STREAM_UPSIZER_SKID_EN
//     - Undefined (default): the accumulator is also the output register.
//       o_ready = !o_valid | i_ready, so there is a combinational path from
//       i_ready to o_ready.
//     - Defined: the accumulator and the output register are separate. The
//       next word fills while the previous word is held. o_ready is
//       registered and is low only in STALL.
//
// Ports:
//   i_slave_clk      clock (FIFO read-side clock)
//   i_slave_reset_n  asynchronous active-low reset
//   i_valid/o_ready  input beat handshake
//   i_data           input beat, DATA_W bits
//   i_last           beat closes the current word early
//   o_valid/i_ready  wide word handshake
//   o_data           wide word; lane k = bits [k*DATA_W +: DATA_W]
//   o_keep           lane k holds a real beat
//   o_last           word was closed by i_last
// -----------------------------------------------------------------------------
module stream_upsizer #(
    parameter int DATA_W  = 32,
    parameter int RATIO_R = 2
) (
    input  logic                              i_slave_clk,
    input  logic                              i_slave_reset_n,
    input  logic                              i_valid,
    output logic                              o_ready,
    input  logic [DATA_W-1:0]                 i_data,
    input  logic                              i_last,
    output logic                              o_valid,
    input  logic                              i_ready,
    output logic [DATA_W*(1<<RATIO_R)-1:0]    o_data,
    output logic [(1<<RATIO_R)-1:0]           o_keep,
    output logic                              o_last
);
    localparam int RATIO  = 1 << RATIO_R;
    localparam int WIDE_W = DATA_W * RATIO;
    localparam logic [RATIO_R-1:0] LAST_LANE = RATIO_R'(RATIO - 1);

    // FILL : accumulating, output free
    // HOLD : output register occupied
    // STALL: accumulator complete while output is still occupied
    //        (only reachable when the skid register is built in)
    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_STALL = 2'd2
    } state_t;

    state_t              state_reg, state_next;
    logic [RATIO_R-1:0]  cnt_reg, cnt_next;
    logic [WIDE_W-1:0]   acc_data_reg, acc_data_next;
    logic [RATIO-1:0]    acc_keep_reg, acc_keep_next;
    logic                acc_last_reg, acc_last_next;

    logic                accept;
    logic                complete;
    logic                word_start;
    logic [WIDE_W-1:0]   merged_data;
    logic [RATIO-1:0]    merged_keep;

    // The first beat of a word clears all other lanes. Unfilled lanes of a
    // short word therefore read as zero, and no separate clear cycle is needed.
    assign word_start = (cnt_reg == '0);
    assign complete   = accept & ((cnt_reg == LAST_LANE) | i_last);

    genvar gi;
    generate
        for (gi = 0; gi < RATIO; gi++) begin : g_lane
            localparam logic [RATIO_R-1:0] LANE = RATIO_R'(gi);
            assign merged_data[gi*DATA_W +: DATA_W] =
                (cnt_reg == LANE) ? i_data :
                (word_start ? {DATA_W{1'b0}} : acc_data_reg[gi*DATA_W +: DATA_W]);
            assign merged_keep[gi] = (cnt_reg == LANE) | (!word_start & acc_keep_reg[gi]);
        end
    endgenerate

`ifdef STREAM_UPSIZER_SKID_EN
    logic [WIDE_W-1:0]   out_data_reg, out_data_next;
    logic [RATIO-1:0]    out_keep_reg, out_keep_next;
    logic                out_last_reg, out_last_next;
    logic                ready_reg, ready_next;

    assign accept  = i_valid & ready_reg;
    assign o_ready = ready_reg;
    assign o_valid = (state_reg != ST_FILL);
    assign o_data  = out_data_reg;
    assign o_keep  = out_keep_reg;
    assign o_last  = out_last_reg;

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        acc_data_next = acc_data_reg;
        acc_keep_next = acc_keep_reg;
        acc_last_next = acc_last_reg;
        out_data_next = out_data_reg;
        out_keep_next = out_keep_reg;
        out_last_next = out_last_reg;
        ready_next    = ready_reg;

        if (accept) begin
            acc_data_next = merged_data;
            acc_keep_next = merged_keep;
            acc_last_next = i_last;
            cnt_next      = complete ? '0 : cnt_reg + 1'b1;
        end

        case (state_reg)
            ST_FILL, ST_HOLD: begin
                if ((state_reg == ST_HOLD) && i_ready) begin
                    state_next = ST_FILL;
                end
                if (complete) begin
                    if ((state_reg == ST_FILL) || i_ready) begin
                        // Output free or draining: the word bypasses the
                        // accumulator straight into the output register.
                        out_data_next = merged_data;
                        out_keep_next = merged_keep;
                        out_last_next = i_last;
                        state_next    = ST_HOLD;
                    end else begin
                        state_next = ST_STALL;
                        ready_next = 1'b0;
                    end
                end
            end
            ST_STALL: begin
                // The accumulator holds a finished word. It moves out on the
                // drain edge, so o_valid stays high without a bubble.
                if (i_ready) begin
                    out_data_next = acc_data_reg;
                    out_keep_next = acc_keep_reg;
                    out_last_next = acc_last_reg;
                    state_next    = ST_HOLD;
                    ready_next    = 1'b1;
                end
            end
            default: begin
                state_next = ST_FILL;
                ready_next = 1'b1;
            end
        endcase
    end

    always_ff @(posedge i_slave_clk or negedge i_slave_reset_n) begin
        if (!i_slave_reset_n) begin
            out_data_reg <= '0;
            out_keep_reg <= '0;
            out_last_reg <= 1'b0;
            ready_reg    <= 1'b1;
        end else begin
            out_data_reg <= out_data_next;
            out_keep_reg <= out_keep_next;
            out_last_reg <= out_last_next;
            ready_reg    <= ready_next;
        end
    end
`else
    // The accumulator doubles as the output register. While a finished word
    // is held, a beat can be taken only in the cycle that drains it.
    assign o_ready = (state_reg == ST_FILL) | i_ready;
    assign accept  = i_valid & o_ready;
    assign o_valid = (state_reg == ST_HOLD);
    assign o_data  = acc_data_reg;
    assign o_keep  = acc_keep_reg;
    assign o_last  = acc_last_reg;

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        acc_data_next = acc_data_reg;
        acc_keep_next = acc_keep_reg;
        acc_last_next = acc_last_reg;

        if (accept) begin
            acc_data_next = merged_data;
            acc_keep_next = merged_keep;
            acc_last_next = i_last;
            cnt_next      = complete ? '0 : cnt_reg + 1'b1;
        end

        case (state_reg)
            ST_FILL: begin
                if (complete) begin
                    state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (i_ready) begin
                    state_next = complete ? ST_HOLD : ST_FILL;
                end
            end
            default: begin
                state_next = ST_FILL;
            end
        endcase
    end
`endif

    always_ff @(posedge i_slave_clk or negedge i_slave_reset_n) begin
        if (!i_slave_reset_n) begin
            state_reg    <= ST_FILL;
            cnt_reg      <= '0;
            acc_data_reg <= '0;
            acc_keep_reg <= '0;
            acc_last_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            acc_data_reg <= acc_data_next;
            acc_keep_reg <= acc_keep_next;
            acc_last_reg <= acc_last_next;
        end
    end

endmodule

// File: tb/tb_stream_upsizer.sv
// -----------------------------------------------------------------------------
// tb_stream_upsizer
//
// Self-checking bench for stream_upsizer with DATA_W=32 and RATIO_R=2.
//
// A packing model watches the input handshakes and builds the expected wide
// words in a queue. Every output handshake is compared against the head of
// that queue. On every cycle the bench also checks three things:
//   - a held word stays stable,
//   - o_valid rises one cycle after a closing beat, when the output was free,
//   - o_ready obeys the rule for the selected build.
// Directed tests add literal expectations that pin the model.
//
// All stimulus and checking run in a single process. Inputs are driven 1 time
// unit after the rising edge, and outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_stream_upsizer;
    localparam int DW = 32;
    localparam int RR = 2;
    localparam int R  = 1 << RR;
    localparam int WW = DW * R;

    logic              clk;
    logic              rst_n;
    logic              i_valid;
    logic              o_ready;
    logic [DW-1:0]     i_data;
    logic              i_last;
    logic              o_valid;
    logic              i_ready;
    logic [WW-1:0]     o_data;
    logic [R-1:0]      o_keep;
    logic              o_last;

    stream_upsizer #(.DATA_W(DW), .RATIO_R(RR)) dut (
        .i_slave_clk     (clk),
        .i_slave_reset_n (rst_n),
        .i_valid         (i_valid),
        .o_ready         (o_ready),
        .i_data          (i_data),
        .i_last          (i_last),
        .o_valid         (o_valid),
        .i_ready         (i_ready),
        .o_data          (o_data),
        .o_keep          (o_keep),
        .o_last          (o_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [WW-1:0] d;
        logic [R-1:0]  k;
        logic          l;
    } word_t;

    word_t          exp_q[$];
    logic [WW-1:0]  m_data;
    int             m_n;
    int             n_checks;
    int             n_fail;
    int             out_words;
    bit             acc_flag;
    bit             prev_hold;
    bit             lat_pend;
    logic [WW-1:0]  h_data;
    logic [R-1:0]   h_keep;
    logic           h_last;
    logic           s_ready;
    logic           s_valid;

    task automatic check(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Falling-edge observation: handshakes, the model, and per-cycle checks.
    task automatic observe();
        word_t w;
        acc_flag = 1'b0;
        if (!rst_n) begin
            exp_q.delete();
            m_n       = 0;
            m_data    = '0;
            prev_hold = 1'b0;
            lat_pend  = 1'b0;
            return;
        end
        s_ready = o_ready;
        s_valid = o_valid;
        if (prev_hold) begin
            check("hold_valid", WW'(o_valid), WW'(1'b1));
            check("hold_data", o_data, h_data);
            check("hold_keep", WW'(o_keep), WW'(h_keep));
            check("hold_last", WW'(o_last), WW'(h_last));
        end
        if (lat_pend) check("latency_valid", WW'(o_valid), WW'(1'b1));
`ifdef STREAM_UPSIZER_SKID_EN
        check("ready_low_only_when_full", WW'(o_ready | o_valid), WW'(1'b1));
`else
        check("ready_comb", WW'(o_ready), WW'(!o_valid | i_ready));
`endif
        if (o_valid && i_ready) begin
            $display("word %0d: data=%h keep=%b last=%b", out_words, o_data, o_keep, o_last);
            if (exp_q.size() == 0) begin
                check("spurious_word", WW'(o_valid), WW'(1'b0));
            end else begin
                w = exp_q.pop_front();
                check("word_data", o_data, w.d);
                check("word_keep", WW'(o_keep), WW'(w.k));
                check("word_last", WW'(o_last), WW'(w.l));
            end
            out_words++;
        end
        lat_pend = 1'b0;
        if (i_valid && o_ready) begin
            acc_flag = 1'b1;
            m_data[m_n*DW +: DW] = i_data;
            m_n++;
            if (m_n == R || i_last) begin
                w.d = m_data;
                w.k = R'((1 << m_n) - 1);
                w.l = i_last;
                exp_q.push_back(w);
                lat_pend = !o_valid || i_ready;
                m_n    = 0;
                m_data = '0;
            end
        end
        prev_hold = o_valid && !i_ready;
        h_data = o_data;
        h_keep = o_keep;
        h_last = o_last;
    endtask

    task automatic tick();
        @(negedge clk);
        observe();
        @(posedge clk);
        #1;
    endtask

    // Presents one beat and waits for it to be taken. Returns the number of
    // cycles spent waiting.
    task automatic send_beat(input logic [DW-1:0] d, input logic l, output int waits);
        i_valid = 1'b1;
        i_data  = d;
        i_last  = l;
        waits   = 0;
        while (1) begin
            tick();
            if (acc_flag) break;
            waits++;
            if (waits > 100) begin
                check("accept_timeout", WW'(waits), WW'(0));
                break;
            end
        end
        i_valid = 1'b0;
        i_last  = 1'b0;
    endtask

    task automatic check_word(input string name, input logic [WW-1:0] d, input logic [R-1:0] k, input logic l);
        check({name, "_valid"}, WW'(o_valid), WW'(1'b1));
        check({name, "_data"}, o_data, d);
        check({name, "_keep"}, WW'(o_keep), WW'(k));
        check({name, "_last"}, WW'(o_last), WW'(l));
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_valid"}, WW'(o_valid), WW'(1'b0));
        check({name, "_data"}, o_data, '0);
        check({name, "_keep"}, WW'(o_keep), '0);
        check({name, "_last"}, WW'(o_last), '0);
        check({name, "_ready"}, WW'(o_ready), WW'(1'b1));
    endtask

    initial begin
        int w;
        int total_waits;
        int accepts;
        int w0;
        int cycles;
        int beats;
        logic [DW-1:0] seq;

        n_checks  = 0;
        n_fail    = 0;
        out_words = 0;
        m_n       = 0;
        m_data    = '0;
        prev_hold = 1'b0;
        lat_pend  = 1'b0;
        rst_n     = 1'b0;
        i_valid   = 1'b0;
        i_data    = '0;
        i_last    = 1'b0;
        i_ready   = 1'b0;

        repeat (3) tick();
        rst_n = 1'b1;
        check_reset_outputs("reset");
        tick();
        check("ready_after_release", WW'(s_ready), WW'(1'b1));

        // Test 1: a full word.
        i_ready = 1'b1;
        send_beat(32'h11, 1'b0, w);
        send_beat(32'h22, 1'b0, w);
        send_beat(32'h33, 1'b0, w);
        send_beat(32'h44, 1'b0, w);
        check_word("t1", 128'h00000044_00000033_00000022_00000011, 4'b1111, 1'b0);
        tick();

        // Test 2: a short word, then the next beat lands in lane 0.
        send_beat(32'hAA, 1'b0, w);
        send_beat(32'hBB, 1'b1, w);
        check_word("t2", 128'h00000000_00000000_000000BB_000000AA, 4'b0011, 1'b1);
        send_beat(32'hCC, 1'b1, w);
        check_word("t2_lane0", 128'h00000000_00000000_00000000_000000CC, 4'b0001, 1'b1);
        tick();

        // Test 3: a word held for 10 cycles with input pressure.
        i_ready = 1'b0;
        for (int k = 1; k <= 4; k++) send_beat(32'h100 + k, 1'b0, w);
        seq = 32'h105;
        accepts = 0;
        i_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            i_data = seq;
            tick();
            if (acc_flag) begin
                accepts++;
                seq++;
            end
`ifndef STREAM_UPSIZER_SKID_EN
            check("t3_ready_low", WW'(s_ready), WW'(1'b0));
`endif
        end
        i_valid = 1'b0;
`ifdef STREAM_UPSIZER_SKID_EN
        check("t3_accepts", WW'(accepts), WW'(4));
        check("t3_ready_end", WW'(s_ready), WW'(1'b0));
`else
        check("t3_accepts", WW'(accepts), WW'(0));
`endif
        check_word("t3", 128'h00000104_00000103_00000102_00000101, 4'b1111, 1'b0);
        i_ready = 1'b1;
        repeat (6) tick();

        // i_last without i_valid does not close a word.
        send_beat(32'h51, 1'b0, w);
        i_last = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("idle_last_no_word", WW'(s_valid), WW'(1'b0));
        end
        i_last = 1'b0;
        send_beat(32'h52, 1'b0, w);
        send_beat(32'h53, 1'b0, w);
        send_beat(32'h54, 1'b0, w);
        check_word("idle_last", 128'h00000054_00000053_00000052_00000051, 4'b1111, 1'b0);

        // i_last on the final lane gives a full word with o_last set.
        send_beat(32'h71, 1'b0, w);
        send_beat(32'h72, 1'b0, w);
        send_beat(32'h73, 1'b0, w);
        send_beat(32'h74, 1'b1, w);
        check_word("last_on_lane3", 128'h00000074_00000073_00000072_00000071, 4'b1111, 1'b1);
        tick();

        // Test 4: 64 back-to-back beats at full rate.
        w0 = out_words;
        total_waits = 0;
        for (int k = 0; k < 64; k++) begin
            send_beat(32'h1000 + k, 1'b0, w);
            total_waits += w;
        end
        repeat (2) tick();
        check("t4_no_stall", WW'(total_waits), WW'(0));
        check("t4_words", WW'(out_words - w0), WW'(16));

        // Test 5: reset in the middle of a word.
        send_beat(32'h61, 1'b0, w);
        send_beat(32'h62, 1'b0, w);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midword_reset");
        tick();
        rst_n = 1'b1;
        send_beat(32'h1, 1'b0, w);
        send_beat(32'h2, 1'b0, w);
        send_beat(32'h3, 1'b0, w);
        send_beat(32'h4, 1'b0, w);
        check_word("t5", 128'h00000004_00000003_00000002_00000001, 4'b1111, 1'b0);
        tick();

        // Test 6: random traffic.
        beats  = 0;
        cycles = 0;
        while (beats < 10000 && cycles < 60000) begin
            i_valid = ($urandom_range(0, 9) < 7);
            i_ready = ($urandom_range(0, 9) < 7);
            i_last  = ($urandom_range(0, 7) == 0);
            i_data  = $urandom;
            tick();
            if (acc_flag) beats++;
            cycles++;
        end
        check("t6_beats", WW'(beats), WW'(10000));
        i_valid = 1'b0;
        i_last  = 1'b0;
        i_ready = 1'b1;
        repeat (5) tick();
        check("drain_queue_empty", WW'(exp_q.size()), WW'(0));
        check("drain_valid_low", WW'(s_valid), WW'(1'b0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
